speedblock_mc: RTL and testbench

Multi-channel, parametrised speed controller with a self-contained, time-multiplexed PI datapath. It has no external ALU port. Each control tick it samples N free-running QEI position counts and derives per-channel speed as a wrap-safe position delta. It then runs one PI update per channel through a single shared multiplier and publishes saturated signed commands for the downstream PWM/H-bridge stage. It sits between the trajectory layer (speed setpoints) and the motor PWM generators.

---
 rtl/speedblock_mc.sv | 258 +++++++++++++++++++++++++
 tb/tb_speedblock_mc.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/speedblock_mc.sv
// speedblock_mc: multi-channel PI speed controller with a time-multiplexed datapath.
// On each prescaler tick it samples all QEI counts and forms wrap-safe speeds.
// It then runs one PI update per channel through a single shared multiplier.
// Optional feature macro: SPEEDBLOCK_ANTIWINDUP_EN. When it is defined, the
// integrator stops accumulating while the command is pinned in the direction
// of the error.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clr            synchronous clear (forces IDLE, zeroes state, re-syncs positions)
//   en             tick prescaler enable
//   sp_i           packed signed setpoints (channel 0 in LSBs)
//   pos_i          packed free-running QEI counts
//   kp_i, ki_i     unsigned gains, Q(frac_bits)
//   speed_o        packed signed measured deltas
//   co_o           packed saturated signed commands
//   co_valid_o     one-cycle pulse after all commands are updated
//   busy_o         sweep in progress
//   overrun_o      sticky: tick arrived while busy

`ifndef CLK_FREQ
`define CLK_FREQ 50000000
`endif
`ifndef PID_SPEED_FREQ
`define PID_SPEED_FREQ 10000
`endif
`ifndef PID_RES
`define PID_RES 16
`endif
`ifndef QEI_RES
`define QEI_RES 16
`endif

module speedblock_mc #(
    parameter int unsigned n_ch      = 2,
    parameter int unsigned clk_freq  = `CLK_FREQ,
    parameter int unsigned pid_freq  = `PID_SPEED_FREQ,
    parameter int unsigned pid_res   = `PID_RES,
    parameter int unsigned qei_res   = `QEI_RES,
    parameter int unsigned frac_bits = 8,
    parameter int unsigned int_res   = pid_res + 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      en,
    input  logic [n_ch*pid_res-1:0]   sp_i,
    input  logic [n_ch*qei_res-1:0]   pos_i,
    input  logic [pid_res-1:0]        kp_i,
    input  logic [pid_res-1:0]        ki_i,
    output logic [n_ch*pid_res-1:0]   speed_o,
    output logic [n_ch*pid_res-1:0]   co_o,
    output logic                      co_valid_o,
    output logic                      busy_o,
    output logic                      overrun_o
);

    localparam int unsigned period = clk_freq / pid_freq;
    localparam int unsigned cnt_w  = (period > 1) ? $clog2(period) : 1;
    localparam int unsigned ch_w   = (n_ch > 1) ? $clog2(n_ch) : 1;
    // Product of a zero-extended gain (pid_res+1) and an integrator-wide operand.
    localparam int unsigned mul_w  = pid_res + 1 + int_res;
    localparam int unsigned wide_w = mul_w + 1;

    localparam logic signed [pid_res-1:0] pid_lim = {1'b0, {(pid_res-1){1'b1}}};
    localparam logic signed [pid_res-1:0] pid_neg = -pid_lim;
    localparam logic signed [int_res-1:0] int_lim = {1'b0, {(int_res-1){1'b1}}};
    localparam logic signed [int_res-1:0] int_neg = -int_lim;
    localparam logic signed [wide_w-1:0]  pid_max_w = wide_w'(pid_lim);
    localparam logic signed [wide_w-1:0]  pid_min_w = wide_w'(pid_neg);
    localparam logic signed [wide_w-1:0]  int_max_w = wide_w'(int_lim);
    localparam logic signed [wide_w-1:0]  int_min_w = wide_w'(int_neg);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_ERR,
        S_PTERM,
        S_ITERM,
        S_OUT,
        S_DONE
    } state_t;

    // Symmetric clamp to the command width.
    function automatic logic signed [pid_res-1:0] sat_pid(input logic signed [wide_w-1:0] x);
        if (x > pid_max_w)      return pid_lim;
        else if (x < pid_min_w) return pid_neg;
        else                    return x[pid_res-1:0];
    endfunction

    // Symmetric clamp to the integrator width.
    function automatic logic signed [int_res-1:0] sat_int(input logic signed [wide_w-1:0] x);
        if (x > int_max_w)      return int_lim;
        else if (x < int_min_w) return int_neg;
        else                    return x[int_res-1:0];
    endfunction

    state_t state_q, state_d;

    logic [cnt_w-1:0] cnt_q;
    logic             tick_c;

    logic [ch_w-1:0]            ch_q;
    logic signed [pid_res-1:0]  speed_q    [n_ch];
    logic signed [pid_res-1:0]  co_q       [n_ch];
    logic [qei_res-1:0]         pos_prev_q [n_ch];
    logic signed [int_res-1:0]  integ_q    [n_ch];
    logic signed [pid_res-1:0]  err_q;
    logic signed [mul_w-1:0]    p_q;
    logic signed [mul_w-1:0]    i_q;
    logic                       co_valid_q;
    logic                       busy_q;
    logic                       overrun_q;

    logic signed [pid_res-1:0]  sp_a    [n_ch];
    logic [qei_res-1:0]         pos_a   [n_ch];
    logic [qei_res-1:0]         delta_a [n_ch];

    logic signed [pid_res-1:0]  sp_cur_c;
    logic signed [pid_res-1:0]  speed_cur_c;
    logic signed [pid_res-1:0]  co_cur_c;
    logic signed [int_res-1:0]  integ_cur_c;
    logic signed [pid_res-1:0]  err_c;
    logic signed [int_res-1:0]  integ_sum_c;
    logic signed [pid_res:0]    mul_a_c;
    logic signed [int_res-1:0]  mul_b_c;
    logic signed [mul_w-1:0]    prod_c;
    logic signed [mul_w-1:0]    shifted_c;
    logic signed [wide_w-1:0]   out_sum_c;
    logic                       hold_int_c;

    // Unpack per-channel inputs and pack per-channel registered outputs.
    for (genvar g = 0; g < n_ch; g++) begin : g_ch
        assign sp_a[g]    = sp_i[g*pid_res +: pid_res];
        assign pos_a[g]   = pos_i[g*qei_res +: qei_res];
        // Modulo subtraction at counter width makes the delta wrap-safe.
        assign delta_a[g] = pos_a[g] - pos_prev_q[g];
        assign speed_o[g*pid_res +: pid_res] = speed_q[g];
        assign co_o[g*pid_res +: pid_res]    = co_q[g];
    end

    assign co_valid_o = co_valid_q;
    assign busy_o     = busy_q;
    assign overrun_o  = overrun_q;

    // Control tick prescaler; holds while en is low.
    assign tick_c = en && (cnt_q == cnt_w'(period - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick_c ? '0 : cnt_q + cnt_w'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; clr overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (tick_c) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_ERR;
            S_ERR:     state_d = S_PTERM;
            S_PTERM:   state_d = S_ITERM;
            S_ITERM:   state_d = S_OUT;
            S_OUT:     state_d = (ch_q == ch_w'(n_ch - 1)) ? S_DONE : S_ERR;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (clr) state_d = S_IDLE;
    end

    // Current-channel operand selection.
    assign sp_cur_c    = sp_a[ch_q];
    assign speed_cur_c = speed_q[ch_q];
    assign co_cur_c    = co_q[ch_q];
    assign integ_cur_c = integ_q[ch_q];

    assign err_c       = sat_pid(wide_w'(sp_cur_c) - wide_w'(speed_cur_c));
    assign integ_sum_c = sat_int(wide_w'(integ_cur_c) + wide_w'(err_c));

    // Shared multiplier: kp*err in PTERM, ki*integ in ITERM.
    assign mul_a_c   = (state_q == S_ITERM) ? {1'b0, ki_i} : {1'b0, kp_i};
    assign mul_b_c   = (state_q == S_ITERM) ? integ_cur_c : int_res'(err_q);
    assign prod_c    = mul_w'(mul_a_c) * mul_w'(mul_b_c);
    assign shifted_c = prod_c >>> frac_bits;
    assign out_sum_c = wide_w'(p_q) + wide_w'(i_q);

`ifdef SPEEDBLOCK_ANTIWINDUP_EN
    // Freeze the integrator while the command is pinned in the error's direction.
    assign hold_int_c = ((co_cur_c == pid_lim) && !err_c[pid_res-1] && (err_c != '0)) ||
                        ((co_cur_c == pid_neg) && err_c[pid_res-1]);
`else
    assign hold_int_c = 1'b0;
`endif

    // Datapath and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(n_ch); i++) begin
                speed_q[i]    <= '0;
                co_q[i]       <= '0;
                pos_prev_q[i] <= '0;
                integ_q[i]    <= '0;
            end
            ch_q       <= '0;
            err_q      <= '0;
            p_q        <= '0;
            i_q        <= '0;
            co_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else if (clr) begin
            // Re-sync positions so the first sweep after clear sees no spike.
            for (int i = 0; i < int'(n_ch); i++) begin
                speed_q[i]    <= '0;
                co_q[i]       <= '0;
                pos_prev_q[i] <= pos_a[i];
                integ_q[i]    <= '0;
            end
            ch_q       <= '0;
            co_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            co_valid_q <= (state_d == S_DONE);
            busy_q     <= (state_d != S_IDLE);
            if (tick_c && (state_q != S_IDLE)) overrun_q <= 1'b1;

            case (state_q)
                S_CAPTURE: begin
                    for (int i = 0; i < int'(n_ch); i++) begin
                        speed_q[i]    <= pid_res'($signed(delta_a[i]));
                        pos_prev_q[i] <= pos_a[i];
                    end
                    ch_q <= '0;
                end
                S_ERR: begin
                    err_q <= err_c;
                    if (!hold_int_c) integ_q[ch_q] <= integ_sum_c;
                end
                S_PTERM: p_q <= shifted_c;
                S_ITERM: i_q <= shifted_c;
                S_OUT: begin
                    co_q[ch_q] <= sat_pid(out_sum_c);
                    if (ch_q != ch_w'(n_ch - 1)) ch_q <= ch_q + ch_w'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_speedblock_mc.sv
// Directed, table-driven bench for speedblock_mc (n_ch=2, 16-bit, tick every 20 clocks)
// plus a second instance with a 5-clock tick period to provoke overrun.
module tb_speedblock_mc;

    logic        clk = 1'b0;
    logic        rst, clr, clr2, en;
    logic [31:0] sp, pos;
    logic [15:0] kp, ki;
    logic [31:0] speed, co, speed2, co2;
    logic        vld, busy, ovr, vld2, busy2, ovr2;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    speedblock_mc #(
        .n_ch(2), .clk_freq(20), .pid_freq(1), .pid_res(16), .qei_res(16),
        .frac_bits(8), .int_res(24)
    ) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .sp_i(sp), .pos_i(pos),
        .kp_i(kp), .ki_i(ki), .speed_o(speed), .co_o(co), .co_valid_o(vld),
        .busy_o(busy), .overrun_o(ovr)
    );

    speedblock_mc #(
        .n_ch(2), .clk_freq(5), .pid_freq(1), .pid_res(16), .qei_res(16),
        .frac_bits(8), .int_res(24)
    ) u_fast (
        .clk(clk), .rst(rst), .clr(clr2), .en(en), .sp_i(sp), .pos_i(pos),
        .kp_i(kp), .ki_i(ki), .speed_o(speed2), .co_o(co2), .co_valid_o(vld2),
        .busy_o(busy2), .overrun_o(ovr2)
    );

    typedef struct {
        bit do_clr;
        int sp0, sp1, pos0, pos1, kp, ki;
        int es0, es1, ec0, ec1;
    } vec_t;

    vec_t vecs[$];

    function automatic int lo(input logic [31:0] x);
        logic signed [15:0] t;
        t = x[15:0];
        return int'(t);
    endfunction

    function automatic int hi(input logic [31:0] x);
        logic signed [15:0] t;
        t = x[31:16];
        return int'(t);
    endfunction

    function automatic void add(input bit c, input int s0, input int s1, input int p0, input int p1,
                                input int gp, input int gi, input int e0, input int e1,
                                input int c0, input int c1);
        vec_t t;
        t.do_clr = c; t.sp0 = s0; t.sp1 = s1; t.pos0 = p0; t.pos1 = p1;
        t.kp = gp; t.ki = gi; t.es0 = e0; t.es1 = e1; t.ec0 = c0; t.ec1 = c1;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (vld) seen = 1'b1;
        end
    endtask

    task automatic wait_busy(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        bit seen;
        @(negedge clk);
        if (t.do_clr) begin
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
        end
        sp  = {16'(t.sp1), 16'(t.sp0)};
        pos = {16'(t.pos1), 16'(t.pos0)};
        kp  = 16'(t.kp);
        ki  = 16'(t.ki);
        wait_valid(seen);
        chk($sformatf("v%0d_valid", idx), int'(seen), 1);
        chk($sformatf("v%0d_speed0", idx), lo(speed), t.es0);
        chk($sformatf("v%0d_speed1", idx), hi(speed), t.es1);
        chk($sformatf("v%0d_co0", idx), lo(co), t.ec0);
        chk($sformatf("v%0d_co1", idx), hi(co), t.ec1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int cnt;

        rst = 1'b1; clr = 1'b0; clr2 = 1'b0; en = 1'b1;
        sp = '0; pos = '0; kp = '0; ki = '0;

        //        clr sp0     sp1     pos0    pos1    kp     ki   spd0 spd1 co0    co1
        add(1'b1, 10,     0,      10,     0,      256,   0,   10,  0,   0,     0);
        add(1'b0, 10,     -50,    20,     20,     256,   0,   10,  20,  0,     -70);
        add(1'b0, 0,      0,      27,     13,     128,   0,   7,   -7,  -4,    3);
        add(1'b0, 1000,   -1000,  27,     13,     32767, 0,   0,   0,   32767, -32767);
        add(1'b0, 0,      0,      'hFFF8, 'h0008, 256,   0,   -35, -5,  35,    5);
        add(1'b0, 0,      0,      'h0008, 'hFFF8, 256,   0,   16,  -16, -16,   16);
        add(1'b0, 32767,  -32768, 'hFFA4, 'h005C, 256,   0,   -100, 100, 32767, -32767);
        add(1'b1, 5,      0,      'hFFA4, 'h005C, 0,     128, 0,   0,   2,     0);
        add(1'b0, 5,      0,      'hFFA4, 'h005C, 0,     128, 0,   0,   5,     0);
        add(1'b0, 5,      0,      'hFFA4, 'h005C, 0,     128, 0,   0,   7,     0);
        add(1'b0, 5,      0,      'hFFA4, 'h005C, 0,     128, 0,   0,   10,    0);
        add(1'b1, 20000,  0,      'hFFA4, 'h005C, 0,     256, 0,   0,   20000, 0);
        add(1'b0, 20000,  0,      'hFFA4, 'h005C, 0,     256, 0,   0,   32767, 0);
        add(1'b0, 20000,  0,      'hFFA4, 'h005C, 0,     256, 0,   0,   32767, 0);
`ifdef SPEEDBLOCK_ANTIWINDUP_EN
        add(1'b0, -20000, 0,      'hFFA4, 'h005C, 0,     256, 0,   0,   20000, 0);
        add(1'b0, -20000, 0,      'hFFA4, 'h005C, 0,     256, 0,   0,   0,     0);
`else
        add(1'b0, -20000, 0,      'hFFA4, 'h005C, 0,     256, 0,   0,   32767, 0);
        add(1'b0, -20000, 0,      'hFFA4, 'h005C, 0,     256, 0,   0,   20000, 0);
`endif
        add(1'b1, 0,      0,      'hFFA4, 'h005C, 256,   0,   0,   0,   0,     0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_co", int'(co), 0);
        chk("rst_speed", int'(speed), 0);
        chk("rst_valid", int'(vld), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovr", int'(ovr), 0);
        chk("rst_ovr_fast", int'(ovr2), 0);
        rst = 1'b0;

        // Overrun on the 5-clock instance: clear at first sweep, set before it completes
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (busy2) seen = 1'b1;
        end
        chk("ovr_first_busy", int'(seen), 1);
        chk("ovr_before", int'(ovr2), 0);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (vld2) seen = 1'b1;
        end
        chk("ovr_sweep_done", int'(seen), 1);
        chk("ovr_after", int'(ovr2), 1);

        // Table
        foreach (vecs[i]) run_vec(vecs[i], i);

        // Latency and per-channel update timing
        @(negedge clk);
        sp = {16'd200, 16'd100}; pos = {16'h005C, 16'hFFA9}; kp = 16'd256; ki = 16'd0;
        wait_busy(seen);
        chk("lat_busy", int'(seen), 1);
        repeat (4) @(negedge clk);
        chk("lat_co0_hold", lo(co), 0);
        @(negedge clk);
        chk("lat_co0_upd", lo(co), 95);
        chk("lat_co1_hold", hi(co), 0);
        repeat (3) @(negedge clk);
        chk("lat_valid_early", int'(vld), 0);
        chk("lat_co1_hold2", hi(co), 0);
        @(negedge clk);
        chk("lat_valid", int'(vld), 1);
        chk("lat_co1_upd", hi(co), 200);
        chk("lat_speed0", lo(speed), 5);
        chk("lat_busy_done", int'(busy), 1);
        @(negedge clk);
        chk("lat_busy_fall", int'(busy), 0);
        chk("lat_valid_pulse", int'(vld), 0);

        // clr during PTERM of channel 0
        pos = {16'h005C, 16'hFFAC};
        wait_busy(seen);
        chk("clr_busy", int'(seen), 1);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_busy_low", int'(busy), 0);
        chk("clr_co", int'(co), 0);
        chk("clr_speed", int'(speed), 0);
        wait_valid(seen);
        chk("clr_next_valid", int'(seen), 1);
        chk("clr_next_speed0", lo(speed), 0);
        chk("clr_next_co0", lo(co), 100);
        chk("clr_next_co1", hi(co), 200);

        // en=0: no new ticks
        @(negedge clk);
        en = 1'b0;
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (vld || busy) cnt++;
        end
        chk("en_off_idle", cnt, 0);
        chk("ovr_normal", int'(ovr), 0);
        en = 1'b1;

        // Asynchronous reset mid-sweep
        pos = {16'h005C, 16'hFFB0};
        wait_busy(seen);
        chk("arst_busy", int'(seen), 1);
        repeat (5) @(negedge clk);
        chk("arst_pre_co0", lo(co), 96);
        chk("arst_pre_speed0", lo(speed), 4);
        #2 rst = 1'b1;
        #1;
        chk("arst_co", int'(co), 0);
        chk("arst_speed", int'(speed), 0);
        chk("arst_busy_low", int'(busy), 0);
        chk("arst_valid", int'(vld), 0);
        chk("arst_ovr_fast", int'(ovr2), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
